segment_display_arbiter: RTL and testbench
==========================================

# segment_display_arbiter

Shares the single `segment_display` write port between two requesters: the CPU MMIO path (port 0) and the debug/monitor path (port 1). It arbitrates round-robin, sequences each accepted request into a one-cycle `write_data`/`write_mask` strobe into `segment_display`, then holds off further grants for a programmable dwell. The dwell keeps every value visible for at least a minimum time before the next writer can overwrite it. Sits between the MMIO/debug fabric and `segment_display`, in the same clock domain.

## Interface
- `HOLD_CYCLES`, default 4: dwell cycles after each write strobe before the next grant; 0 allowed.
- `clk_i`  in  1  system clock; all logic on rising edge.
- `reset_i`  in  1  asynchronous, active-low reset (asserted when 0).
- `req_valid_i`  in  2  per-requester request valid; bit 0 = CPU, bit 1 = debug.
- `req_ready_o`  out  2  per-requester grant/accept; at most one bit high.
- `req_data_i`  in  2x32 (`word_t`)  per-requester display word.
- `req_mask_i`  in  2x4  per-requester byte mask.
- `write_data_o`  out  32 (`word_t`)  to `segment_display.write_data_i`.
- `write_mask_o`  out  4  to `segment_display.write_mask_i`; nonzero only in WRITE.
- `owner_o`  out  2  one-hot requester of the most recent accepted request; 2'b00 until the first accept.
- `busy_o`  out  1  high in WRITE or HOLD.

## Operation
- FSM states: IDLE, WRITE, HOLD.
- **IDLE**
  - Arbitrate among `req_valid_i`.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester selected by the round-robin pointer `rr` wins.
  - `req_ready_o[winner]` is driven combinationally high in IDLE only.
  - Handshake occurs when `valid & ready` at a rising edge.
  - On handshake: latch data and mask into output registers, set `owner_o` to the winner, set `rr` to the other requester, go to WRITE.
- **WRITE** (exactly 1 cycle)
  - `write_mask_o` = latched mask; `write_data_o` = latched data.
  - Next state: HOLD if `HOLD_CYCLES > 0` and the latched mask is nonzero; otherwise IDLE.
  - On entering HOLD, load the dwell counter with `HOLD_CYCLES-1`.
- **HOLD**
  - `write_mask_o` = 0; `write_data_o` keeps the last value.
  - Counter decrements each cycle; at 0, go to IDLE.
  - `req_ready_o` = 0 throughout.
- Counter width: `$clog2(HOLD_CYCLES+1)`, minimum 1 bit; it never wraps.
- `rr` resets to 0 (CPU first). It updates only on handshake, so a requester that is the sole valid one does not disturb fairness.
- Requester protocol:
  - Once valid is raised, data and mask must stay stable until ready.
  - Dropping valid before ready is permitted; the arbiter then simply does not accept that request.
- A zero-mask request is accepted normally. It produces a WRITE cycle with mask 0, which has no effect, and skips HOLD.
- Reset values (async on `reset_i`=0): state IDLE, `write_mask_o`=0, `write_data_o`=0, `owner_o`=0, `busy_o`=0, `rr`=0, counter=0, `req_ready_o`=0.
- Reset asserted mid-WRITE or mid-HOLD aborts immediately to the reset values. The write strobe is cut, and no pending grant survives.

## Timing
- Handshake at edge N. Then:
  - `write_mask_o` is valid in cycle N+1.
  - HOLD occupies cycles N+2 .. N+1+HOLD_CYCLES.
  - IDLE and the next possible grant are in cycle N+2+HOLD_CYCLES.
- Throughput: one write per `2+HOLD_CYCLES` cycles. With `HOLD_CYCLES`=0 or a zero mask, one write per 2 cycles.
- `req_ready_o` depends combinationally on `req_valid_i`, state and `rr`. There is no valid-to-valid combinational loop, because requesters must not gate valid on ready.
- Outputs `write_data_o`, `write_mask_o`, `owner_o`, `busy_o` are registered.

## Test plan
Parameters for all scenarios: `HOLD_CYCLES`=4, clock 10 ns, reset low for 2 cycles.
- **Reset:** during and after reset with no requests → all outputs 0, `req_ready_o`=00.
- **Single write:** CPU valid with `32'h12345678`/`4'b1111` → `req_ready_o`=01 in the same cycle; `write_mask_o`=1111 and `write_data_o`=12345678 for exactly 1 cycle; `busy_o` high for 5 cycles; `owner_o`=01.
- **Contention:** both requesters held valid continuously (CPU `32'hAAAA0000`, debug `32'h0000BBBB`) → grants alternate CPU, debug, CPU; write strobes are 6 cycles apart.
- **Zero mask:** debug valid with mask 0000 → accepted, WRITE cycle with `write_mask_o`=0000, back in IDLE 2 cycles after the handshake with no HOLD; `write_data_o` is updated.
- **Reset mid-operation:** `reset_i` driven low 2 cycles into HOLD → outputs go to 0 asynchronously. After release with CPU still valid, the CPU is granted first (`rr`=0).
- **Zero-dwell build:** `HOLD_CYCLES`=0 with CPU valid continuously → a write strobe every 2 cycles and `busy_o` high only in the WRITE cycles.

Source files
------------

// File: rtl/segment_display_arbiter.sv
// Round-robin arbiter that shares the segment_display write port between the CPU
// MMIO path and the debug path, with a programmable dwell after each write strobe.
package segment_display_arbiter_pkg;
  typedef logic [31:0] word_t;
endpackage

module segment_display_arbiter
  import segment_display_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  word_t [1:0]     req_data_i,
  input  logic [1:0][3:0] req_mask_i,
  output word_t           write_data_o,
  output logic [3:0]      write_mask_o,
  output logic [1:0]      owner_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam bit          HAS_HOLD  = (HOLD_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  word_t              write_data_q, write_data_d;
  logic [3:0]         write_mask_q, write_mask_d;
  logic [1:0]         owner_q, owner_d;
  logic               busy_q, busy_d;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               winner;
  logic               hs;

  // Sole valid requester wins; on contention the rr pointer decides (0 = CPU).
  always_comb begin
    winner      = req_valid_i[1] & (~req_valid_i[0] | rr_q);
    req_ready_o = 2'b00;
    if ((state_q == ST_IDLE) && reset_i && (req_valid_i != 2'b00)) begin
      req_ready_o = 2'b01 << winner;
    end
    hs = |(req_valid_i & req_ready_o);
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; write_mask_q still holds the accepted mask during WRITE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (hs) state_d = ST_WRITE;
      ST_WRITE: state_d = (HAS_HOLD && (write_mask_q != 4'h0)) ? ST_HOLD : ST_IDLE;
      ST_HOLD:  if (cnt_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, rr pointer and dwell counter
  always_comb begin
    write_data_d = write_data_q;
    write_mask_d = 4'h0;
    owner_d      = owner_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    busy_d       = (state_d != ST_IDLE);
    if (hs) begin
      write_data_d = req_data_i[winner];
      write_mask_d = req_mask_i[winner];
      owner_d      = 2'b01 << winner;
      rr_d         = ~winner;
    end
    if ((state_q == ST_WRITE) && (state_d == ST_HOLD)) begin
      cnt_d = CNT_W'(HOLD_LOAD);
    end else if ((state_q == ST_HOLD) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      write_data_q <= '0;
      write_mask_q <= 4'h0;
      owner_q      <= 2'b00;
      busy_q       <= 1'b0;
      rr_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      write_data_q <= write_data_d;
      write_mask_q <= write_mask_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign write_data_o = write_data_q;
  assign write_mask_o = write_mask_q;
  assign owner_o      = owner_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_segment_display_arbiter.sv
// Bench for segment_display_arbiter: directed scenarios plus randomized traffic
// checked against a timeline model of grants, strobes and dwell.
module tb_segment_display_arbiter;
  import segment_display_arbiter_pkg::*;

  localparam int HOLD = 4;

  logic            clk = 1'b0;
  logic            reset_i = 1'b0;
  logic [1:0]      valid = '0, ready;
  word_t [1:0]     data = '0;
  logic [1:0][3:0] mask = '0;
  word_t           wdata;
  logic [3:0]      wmask;
  logic [1:0]      owner;
  logic            busy;

  logic [1:0]      z_valid = '0, z_ready;
  word_t [1:0]     z_data = '0;
  logic [1:0][3:0] z_mask = '0;
  word_t           z_wdata;
  logic [3:0]      z_wmask;
  logic [1:0]      z_owner;
  logic            z_busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  segment_display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_valid_i(valid), .req_ready_o(ready),
    .req_data_i(data), .req_mask_i(mask), .write_data_o(wdata),
    .write_mask_o(wmask), .owner_o(owner), .busy_o(busy)
  );

  segment_display_arbiter #(.HOLD_CYCLES(0)) dut_z (
    .clk_i(clk), .reset_i(reset_i), .req_valid_i(z_valid), .req_ready_o(z_ready),
    .req_data_i(z_data), .req_mask_i(z_mask), .write_data_o(z_wdata),
    .write_mask_o(z_wmask), .owner_o(z_owner), .busy_o(z_busy)
  );

  task automatic do_reset();
    @(negedge clk);
    valid = '0; z_valid = '0; reset_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; valid = '0; z_valid = '0;
    repeat (2) begin
      @(negedge clk); #1;
      total++;
      if ({ready, wmask, wdata, owner, busy, z_ready, z_wmask, z_wdata, z_owner, z_busy} !== 82'd0) begin
        bad++;
        $display("FAIL reset_during got=%h/%h required all zero", {ready, wmask, wdata, owner, busy},
                 {z_ready, z_wmask, z_wdata, z_owner, z_busy});
      end
    end
    reset_i = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      total++;
      if ({ready, wmask, wdata, owner, busy} !== 41'd0) begin
        bad++;
        $display("FAIL reset_after got=%h required 0", {ready, wmask, wdata, owner, busy});
      end
    end
  endtask

  task automatic test_single_write();
    do_reset();
    valid[0] = 1'b1; data[0] = 32'h12345678; mask[0] = 4'hF;
    #1;
    total++;
    if (ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b required 01", ready); end
    @(negedge clk);
    valid = '0;
    #1;
    total++;
    if ({ready, wmask, wdata, owner, busy} !== {2'b00, 4'hF, 32'h12345678, 2'b01, 1'b1}) begin
      bad++;
      $display("FAIL single_strobe got=%h required %h", {ready, wmask, wdata, owner, busy},
               {2'b00, 4'hF, 32'h12345678, 2'b01, 1'b1});
    end
    for (int k = 0; k < HOLD; k++) begin
      @(negedge clk); #1;
      total++;
      if ({wmask, wdata, owner, busy} !== {4'h0, 32'h12345678, 2'b01, 1'b1}) begin
        bad++;
        $display("FAIL single_hold%0d got=%h required %h", k, {wmask, wdata, owner, busy},
                 {4'h0, 32'h12345678, 2'b01, 1'b1});
      end
    end
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b required 0", busy); end
  endtask

  task automatic test_contention();
    int g_own[$];
    int s_cyc[$];
    word_t s_dat[$];
    do_reset();
    valid = 2'b11; data[0] = 32'hAAAA0000; data[1] = 32'h0000BBBB; mask[0] = 4'hF; mask[1] = 4'hF;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (ready == 2'b01) g_own.push_back(0);
      else if (ready == 2'b10) g_own.push_back(1);
      if (wmask != 4'h0) begin s_cyc.push_back(c); s_dat.push_back(wdata); end
      @(negedge clk);
    end
    valid = '0;
    total++;
    if (g_own.size() < 3 || s_cyc.size() < 3) begin
      bad++;
      $display("FAIL contention_count grants=%0d strobes=%0d required >=3", g_own.size(), s_cyc.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if (g_own[j] != (j % 2)) begin
          bad++; $display("FAIL contention_owner%0d got=%0d required %0d", j, g_own[j], j % 2);
        end
        total++;
        if (s_dat[j] !== ((j % 2 == 0) ? 32'hAAAA0000 : 32'h0000BBBB)) begin
          bad++; $display("FAIL contention_data%0d got=%h", j, s_dat[j]);
        end
      end
      for (int j = 1; j < 3; j++) begin
        total++;
        if (s_cyc[j] - s_cyc[j-1] != 2 + HOLD) begin
          bad++; $display("FAIL contention_gap%0d got=%0d required %0d", j, s_cyc[j] - s_cyc[j-1], 2 + HOLD);
        end
      end
    end
  endtask

  task automatic test_zero_mask();
    do_reset();
    valid[1] = 1'b1; data[1] = 32'hCAFEF00D; mask[1] = 4'h0;
    #1;
    total++;
    if (ready !== 2'b10) begin bad++; $display("FAIL zmask_ready got=%b required 10", ready); end
    @(negedge clk);
    valid = '0;
    #1;
    total++;
    if ({wmask, wdata, owner, busy} !== {4'h0, 32'hCAFEF00D, 2'b10, 1'b1}) begin
      bad++;
      $display("FAIL zmask_write got=%h required %h", {wmask, wdata, owner, busy}, {4'h0, 32'hCAFEF00D, 2'b10, 1'b1});
    end
    @(negedge clk);
    valid[0] = 1'b1; data[0] = 32'h0; mask[0] = 4'h1;
    #1;
    total++;
    if ({busy, ready} !== {1'b0, 2'b01}) begin
      bad++; $display("FAIL zmask_idle got busy=%b ready=%b required 0/01", busy, ready);
    end
    @(negedge clk);
    valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid[0] = 1'b1; data[0] = 32'h5A5A1234; mask[0] = 4'h3;
    #1;
    total++;
    if (ready !== 2'b01) begin bad++; $display("FAIL mid_ready got=%b required 01", ready); end
    repeat (3) @(negedge clk);
    valid[1] = 1'b1; data[1] = 32'h0BADBEEF; mask[1] = 4'hC;
    #1;
    total++;
    if ({wmask, busy, owner} !== {4'h0, 1'b1, 2'b01}) begin
      bad++; $display("FAIL mid_hold got=%h required %h", {wmask, busy, owner}, {4'h0, 1'b1, 2'b01});
    end
    #1 reset_i = 1'b0;
    #1;
    total++;
    if ({ready, wmask, wdata, owner, busy} !== 41'd0) begin
      bad++; $display("FAIL mid_async got=%h required 0", {ready, wmask, wdata, owner, busy});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    total++;
    if (ready !== 2'b01) begin bad++; $display("FAIL mid_rr_after got=%b required 01", ready); end
    @(negedge clk);
    valid = '0;
  endtask

  task automatic test_zero_dwell();
    do_reset();
    z_valid[0] = 1'b1; z_data[0] = 32'h600DF00D; z_mask[0] = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++;
      if ((k % 2) == 0) begin
        if ({z_ready, z_wmask, z_busy} !== {2'b01, 4'h0, 1'b0}) begin
          bad++; $display("FAIL zdwell_idle%0d got=%h required %h", k, {z_ready, z_wmask, z_busy}, {2'b01, 4'h0, 1'b0});
        end
      end else begin
        if ({z_ready, z_wmask, z_busy, z_wdata} !== {2'b00, 4'hF, 1'b1, 32'h600DF00D}) begin
          bad++; $display("FAIL zdwell_write%0d got=%h required %h", k, {z_ready, z_wmask, z_busy, z_wdata},
                          {2'b00, 4'hF, 1'b1, 32'h600DF00D});
        end
      end
      @(negedge clk);
    end
    z_valid = '0;
  endtask

  // Model: a grant in cycle c strobes in c+1 and frees the port at c+2(+HOLD if mask != 0).
  task automatic test_random(input int n);
    int cyc, next_free, strobe_at, w;
    logic rr_m;
    word_t m_data;
    logic [3:0] m_mask;
    logic [1:0] m_owner, exp_ready, granted;
    logic [40:0] exp_v, got_v;
    do_reset();
    cyc = 0; next_free = 0; strobe_at = -1; rr_m = 1'b0; w = 0;
    m_data = '0; m_mask = 4'h0; m_owner = 2'b00; granted = 2'b00;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (granted[k] || !valid[k]) begin
          valid[k] = ($urandom_range(0, 1) == 1);
          data[k] = $urandom;
          mask[k] = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          valid[k] = 1'b0;
        end
      end
      #1;
      exp_ready = 2'b00;
      if (cyc >= next_free && valid != 2'b00) begin
        w = (valid == 2'b11) ? int'(rr_m) : (valid[1] ? 1 : 0);
        exp_ready[w] = 1'b1;
      end
      exp_v = {exp_ready, (cyc == strobe_at) ? m_mask : 4'h0, m_data, m_owner, cyc < next_free};
      got_v = {ready, wmask, wdata, owner, busy};
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d got=%h required %h", cyc, got_v, exp_v);
      end
      granted = valid & exp_ready;
      if (granted != 2'b00) begin
        strobe_at = cyc + 1;
        m_mask = mask[w];
        m_data = data[w];
        m_owner = granted;
        next_free = cyc + 2 + ((mask[w] != 4'h0) ? HOLD : 0);
        rr_m = (w == 0);
      end
      cyc++;
      @(negedge clk);
    end
    valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_zero_mask();
    test_reset_mid();
    test_zero_dwell();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
